// File: rtl/matrix_memory_port_pkg.sv
// Shared definitions for the matrix-multiply memory responder.
//   - Element width, matrix dimension and element count.
//   - Controller select encodings for A, B, C and none.
//   - Responder state encoding and a row/col position type with helpers.
package matrix_memory_port_pkg;

  localparam int DATA_W = 8;
  localparam int DIM    = 3;   // row/col are 2-bit indices, so DIM <= 4
  localparam int N_ELEM = DIM * DIM;

  // Highest legal row/col index, in the width of the index ports.
  localparam logic [1:0] LAST_IDX = 2'(DIM - 1);

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_CLR = 2'd2,
    ST_UNLOAD   = 2'd3
  } state_e;

  // Element position inside one DIM x DIM matrix.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } rc_t;

  // Next position in row-major order; wraps to (0,0) after the last element.
  function automatic rc_t next_rc(input rc_t p);
    rc_t n;
    n = p;
    if (p.col == LAST_IDX) begin
      n.col = 2'd0;
      n.row = (p.row == LAST_IDX) ? 2'd0 : p.row + 2'd1;
    end else begin
      n.col = p.col + 2'd1;
    end
    return n;
  endfunction

  function automatic logic is_last_rc(input rc_t p);
    return (p.row == LAST_IDX) && (p.col == LAST_IDX);
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// One DIM x DIM matrix of DATA_W-bit elements.
//   clk       - clock
//   clear_i   - synchronous clear of every element
//   we_i      - write strobe; ignored when the address is out of range
//   wrow_i/wcol_i/wdata_i - write address and value
//   rrow_i/rcol_i - combinational read address
//   rdata_o   - addressed element, 0 when the address is out of range
module matrix_bank
  import matrix_memory_port_pkg::*;
(
  input  logic              clk,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [1:0]        wrow_i,
  input  logic [1:0]        wcol_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        rrow_i,
  input  logic [1:0]        rcol_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DIM][DIM];

  logic w_in_range;
  logic r_in_range;

  assign w_in_range = (wrow_i <= LAST_IDX) && (wcol_i <= LAST_IDX);
  assign r_in_range = (rrow_i <= LAST_IDX) && (rcol_i <= LAST_IDX);

  // NOTE: the storage is cleared element by element because the block must
  // read back all zeros after reset; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          // NOTE: non-blocking assignment so every flop samples pre-edge values.
          mem_q[i][j] <= '0;
        end
      end
    end else if (we_i && w_in_range) begin
      mem_q[wrow_i][wcol_i] <= wdata_i;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves rdata_o unassigned (no latch).
    rdata_o = '0;
    if (r_in_range) begin
      rdata_o = mem_q[rrow_i][rcol_i];
    end
  end

endmodule

// File: rtl/matrix_memory_port.sv
// Responder side of the matrix-multiply memory interface.
// Holds A, B (loaded from the host byte stream) and C (written by the
// controller), starts the controller, waits for done and streams C out.
//   clk, reset                         - clock, synchronous active-high reset
//   matrix_select/row/col              - controller element address
//   write_enable/write_data            - controller write (C only)
//   read_data                          - addressed element, combinational
//   start/done                         - controller handshake
//   load_valid/load_data/load_ready    - host load stream (A then B)
//   out_valid/out_data/out_ready       - host result stream (C)
//   busy                               - high outside LOAD
module matrix_memory_port
  import matrix_memory_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        matrix_select,
  input  logic [1:0]        row,
  input  logic [1:0]        col,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              start,
  input  logic              done,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  state_e            state_q,     state_d;
  rc_t               ld_pos_q,    ld_pos_d;    // position inside A or B
  logic              ld_mat_q,    ld_mat_d;    // 0 = loading A, 1 = loading B
  rc_t               out_pos_q,   out_pos_d;   // C element held in out_data
  logic              start_q,     start_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic              load_accept;
  logic              out_accept;
  logic              stream_mode;
  rc_t               out_pos_next;
  rc_t               c_raddr;
  logic [DATA_W-1:0] a_rdata, b_rdata, c_rdata;

  assign load_accept  = (state_q == ST_LOAD) && load_valid;
  assign out_accept   = out_valid_q && out_ready;
  assign out_pos_next = next_rc(out_pos_q);

  // While streaming, C's single read port prefetches the element that will
  // be presented next: (0,0) on entry, then the successor of the current one.
  // The controller is idle by then, so it never needs C's port.
  assign stream_mode = (state_q == ST_WAIT_CLR) || (state_q == ST_UNLOAD);
  always_comb begin
    c_raddr = '{row: row, col: col};
    if (state_q == ST_WAIT_CLR) begin
      c_raddr = '0;
    end else if (state_q == ST_UNLOAD) begin
      c_raddr = out_pos_next;
    end
  end

  matrix_bank u_bank_a (
    .clk     (clk),
    .clear_i (reset),
    .we_i    (load_accept && !ld_mat_q),
    .wrow_i  (ld_pos_q.row),
    .wcol_i  (ld_pos_q.col),
    .wdata_i (load_data),
    .rrow_i  (row),
    .rcol_i  (col),
    .rdata_o (a_rdata)
  );

  matrix_bank u_bank_b (
    .clk     (clk),
    .clear_i (reset),
    .we_i    (load_accept && ld_mat_q),
    .wrow_i  (ld_pos_q.row),
    .wcol_i  (ld_pos_q.col),
    .wdata_i (load_data),
    .rrow_i  (row),
    .rcol_i  (col),
    .rdata_o (b_rdata)
  );

  matrix_bank u_bank_c (
    .clk     (clk),
    .clear_i (reset),
    .we_i    (write_enable && (matrix_select == SEL_C)),
    .wrow_i  (row),
    .wcol_i  (col),
    .wdata_i (write_data),
    .rrow_i  (c_raddr.row),
    .rcol_i  (c_raddr.col),
    .rdata_o (c_rdata)
  );

  // Controller read mux; the banks already return 0 for out-of-range indices.
  always_comb begin
    read_data = '0;
    case (matrix_select)
      SEL_A:   read_data = a_rdata;
      SEL_B:   read_data = b_rdata;
      SEL_C:   read_data = stream_mode ? '0 : c_rdata;
      default: read_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_pos_d    = ld_pos_q;
    ld_mat_d    = ld_mat_q;
    out_pos_d   = out_pos_q;
    start_d     = start_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_LOAD: begin
        if (load_accept) begin
          if (ld_mat_q && is_last_rc(ld_pos_q)) begin
            ld_pos_d = '0;
            ld_mat_d = 1'b0;
            start_d  = 1'b1;
            state_d  = ST_RUN;
          end else begin
            ld_pos_d = next_rc(ld_pos_q);
            // Crossing from the last A element to the first B element.
            if (is_last_rc(ld_pos_q)) begin
              ld_mat_d = 1'b1;
            end
          end
        end
      end

      ST_RUN: begin
        if (done) begin
          start_d = 1'b0;
          state_d = ST_WAIT_CLR;
        end
      end

      ST_WAIT_CLR: begin
        // done falling means the controller is idle again; c_raddr is (0,0).
        if (!done) begin
          out_pos_d   = '0;
          out_data_d  = c_rdata;
          out_valid_d = 1'b1;
          state_d     = ST_UNLOAD;
        end
      end

      ST_UNLOAD: begin
        if (out_accept) begin
          if (is_last_rc(out_pos_q)) begin
            out_pos_d   = '0;
            out_valid_d = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            out_pos_d  = out_pos_next;
            out_data_d = c_rdata;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      ld_pos_q    <= '0;
      ld_mat_q    <= 1'b0;
      out_pos_q   <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_pos_q    <= ld_pos_d;
      ld_mat_q    <= ld_mat_d;
      out_pos_q   <= out_pos_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign start      = start_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != ST_LOAD);
  // Not ready while reset is held; ready from the first cycle after release.
  assign load_ready = (state_q == ST_LOAD) && !reset;

endmodule

// File: tb/tb_matrix_memory_port.sv
// Self-checking bench for matrix_memory_port: directed load/run/unload
// sequences with a controller model; the result stream is checked by a
// monitor against a queue of hand-computed expected bytes.
module tb_matrix_memory_port;
  import matrix_memory_port_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        matrix_select = SEL_NONE;
  logic [1:0]        row = 2'd0;
  logic [1:0]        col = 2'd0;
  logic              write_enable = 1'b0;
  logic [DATA_W-1:0] write_data = '0;
  logic [DATA_W-1:0] read_data;
  logic              start;
  logic              done = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy;

  int errors   = 0;
  int checks   = 0;
  int hs_total = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  matrix_memory_port dut (
    .clk           (clk),
    .reset         (reset),
    .matrix_select (matrix_select),
    .row           (row),
    .col           (col),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .read_data     (read_data),
    .start         (start),
    .done          (done),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result-stream monitor: pops one expected byte per handshake and checks
  // that a stalled byte is held unchanged into the next cycle.
  initial begin : monitor
    logic       stall;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall      = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got 0x%0h expected no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
        hs_total++;
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic load_all(input logic [7:0] bytes [18]);
    for (int i = 0; i < 18; i++) begin
      load_valid = 1'b1;
      load_data  = bytes[i];
      if (i == 17) check("start_before_last", 32'(start), 32'd0);
      tick();
    end
    load_valid = 1'b0;
    check("start_after_last", 32'(start), 32'd1);
    check("busy_in_run", 32'(busy), 32'd1);
    check("ready_in_run", 32'(load_ready), 32'd0);
  endtask

  task automatic ctrl_read(input logic [1:0] sel, input logic [1:0] r, input logic [1:0] c,
                           output logic [7:0] d);
    matrix_select = sel;
    row           = r;
    col           = c;
    #1;
    d             = read_data;
    matrix_select = SEL_NONE;
  endtask

  task automatic ctrl_write(input logic [1:0] sel, input logic [1:0] r, input logic [1:0] c,
                            input logic [7:0] v);
    matrix_select = sel;
    row           = r;
    col           = c;
    write_data    = v;
    write_enable  = 1'b1;
    tick();
    write_enable  = 1'b0;
    matrix_select = SEL_NONE;
  endtask

  // Controller model: wait for start, multiply through the port, write C,
  // then run the done handshake.
  task automatic run_controller();
    int         waited;
    logic [7:0] a [3][3];
    logic [7:0] b [3][3];
    int         sum;
    waited = 0;
    while (!start && waited < 50) begin
      tick();
      waited++;
    end
    check("start_seen", 32'(start), 32'd1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ctrl_read(SEL_A, 2'(i), 2'(j), a[i][j]);
        ctrl_read(SEL_B, 2'(i), 2'(j), b[i][j]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum = 0;
        for (int k = 0; k < 3; k++) sum += int'(a[i][k]) * int'(b[k][j]);
        ctrl_write(SEL_C, 2'(i), 2'(j), 8'(sum));
      end
    end
    done = 1'b1;
    tick();
    check("start_drop", 32'(start), 32'd0);
    check("busy_wait_clr", 32'(busy), 32'd1);
    tick();
    check("no_valid_while_done", 32'(out_valid), 32'd0);
    done = 1'b0;
    tick();
    check("valid_after_done_low", 32'(out_valid), 32'd1);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1,0,0,...
  task automatic unload(input int mode);
    int target;
    target = hs_total + N_ELEM;
    for (int k = 0; k < 200; k++) begin
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      tick();
      if (hs_total >= target) break;
    end
    out_ready = 1'b0;
    check("stream_count", 32'(hs_total), 32'(target));
    check("busy_after_unload", 32'(busy), 32'd0);
    check("valid_after_unload", 32'(out_valid), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    logic [7:0] bytes [18];
    logic [7:0] d;

    // Reset state.
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ready_held", 32'(load_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", 32'(load_ready), 32'd1);

    // Run 1: A = identity, B = 1..9 -> C = B.
    for (int i = 0; i < 9; i++) begin
      bytes[i]     = (i % 4 == 0) ? 8'd1 : 8'd0;
      bytes[9 + i] = 8'(i + 1);
    end
    for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
    load_all(bytes);
    run_controller();
    unload(0);

    // Controller port checks, in LOAD with A = identity, C = 1..9.
    ctrl_read(SEL_NONE, 2'd1, 2'd1, d);
    check("rd_select_none", 32'(d), 32'd0);
    ctrl_read(SEL_A, 2'd3, 2'd0, d);
    check("rd_row_oob", 32'(d), 32'd0);
    ctrl_read(SEL_C, 2'd0, 2'd3, d);
    check("rd_col_oob", 32'(d), 32'd0);
    ctrl_read(SEL_A, 2'd1, 2'd1, d);
    check("rd_a11", 32'(d), 32'd1);
    ctrl_write(SEL_A, 2'd0, 2'd0, 8'h77);
    ctrl_read(SEL_A, 2'd0, 2'd0, d);
    check("wr_a_ignored", 32'(d), 32'd1);
    ctrl_write(SEL_B, 2'd0, 2'd1, 8'h77);
    ctrl_read(SEL_B, 2'd0, 2'd1, d);
    check("wr_b_ignored", 32'(d), 32'd2);
    ctrl_read(SEL_C, 2'd1, 2'd2, d);
    check("rd_c12_before", 32'(d), 32'd6);
    ctrl_write(SEL_C, 2'd1, 2'd2, 8'h5C);
    ctrl_read(SEL_C, 2'd1, 2'd2, d);
    check("wr_c12", 32'(d), 32'h5C);

    // Run 2: all 16 -> each C element 768 truncated to 0.
    for (int i = 0; i < 18; i++) bytes[i] = 8'd16;
    for (int i = 0; i < 9; i++) exp_q.push_back(8'd0);
    load_all(bytes);
    run_controller();
    unload(0);

    // Run 3: host bytes during RUN ignored; throttled unload of 0x0A..0x12.
    for (int i = 0; i < 9; i++) begin
      bytes[i]     = (i % 4 == 0) ? 8'd1 : 8'd0;
      bytes[9 + i] = 8'(8'h0A + i);
    end
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h0A + i));
    load_all(bytes);
    load_valid = 1'b1;
    load_data  = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      check("ready_low_in_run", 32'(load_ready), 32'd0);
      tick();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ctrl_read(SEL_A, 2'(i), 2'(j), d);
        check("a_kept", 32'(d), (i == j) ? 32'd1 : 32'd0);
        ctrl_read(SEL_B, 2'(i), 2'(j), d);
        check("b_kept", 32'(d), 32'h0A + 32'(i * 3 + j));
      end
    end
    run_controller();
    unload(1);

    // Reset during RUN.
    for (int i = 0; i < 18; i++) bytes[i] = 8'(i + 3);
    load_all(bytes);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_start", 32'(start), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(load_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          ctrl_read(2'(s), 2'(i), 2'(j), d);
          check("mid_rst_cleared", 32'(d), 32'd0);
        end
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
